program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits directly upstream of the single-cycle processor. It receives a program image as a byte stream over a valid/ready handshake, writes it word-by-word into instruction memory, and checks an XOR checksum. On success it releases the processor from reset with the image's start address on `start_pc`; on failure it keeps the processor in reset and flags `error`.

## Interface
- `MAX_WORDS`, default 64: instruction-memory depth in words; an image with a larger word count is rejected.
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-high; one clock, synchronous active-high reset (already decided).
- `rx_valid` input 1: byte on `rx_data` is valid.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader accepts a byte this cycle; a transfer happens when `rx_valid & rx_ready`.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output 32: byte address of the word being written.
- `imem_wdata` output 32: word being written.
- `start_pc` output 32: image start address; drives processor `startPC`.
- `proc_reset_l` output 1: drives processor `Reset_L`; low holds the processor in reset.
- `done` output 1: image loaded and verified; processor running.
- `error` output 1: sticky until `Reset`; set on a malformed or corrupt image.

## Operation
- Stream format, with every multi-byte field MSB first:
  - 4 bytes start address.
  - 2 bytes word count N.
  - N×4 bytes payload.
  - 1 checksum byte equal to the XOR of all preceding bytes (header and payload).
- States:
  - HDR_PC: collect 4 bytes.
  - HDR_CNT: collect 2 bytes.
  - PAYLOAD: collect 4 bytes per word.
  - WRITE: issue the strobe.
  - CHECK: compare the checksum byte.
  - RUN: processor running.
  - ERROR: image rejected.
- Transitions:
  - HDR_PC→HDR_CNT after the 4th byte. If address bits [1:0] ≠ 0 → ERROR.
  - HDR_CNT: if N > MAX_WORDS → ERROR. If N = 0 → CHECK. Otherwise → PAYLOAD.
  - PAYLOAD→WRITE after the 4th byte of each word.
  - WRITE: → PAYLOAD if words remain, else → CHECK.
  - CHECK: on a match → RUN, on a mismatch → ERROR.
  - RUN and ERROR are terminal until `Reset`.
- Word `i` (0-based) is written to `imem_addr = start_pc + 4*i`. The sum is modulo 2^32 and wraps silently.
- `rx_ready` is 1 in HDR_PC, HDR_CNT, PAYLOAD and CHECK; it is 0 in WRITE, RUN and ERROR.
- Bytes offered while `rx_ready` = 0 are not consumed. They are held by the sender per the handshake.
- A running XOR accumulator is updated on every accepted byte except the checksum byte itself.
- Byte counter is 2 bits; word counter is 16 bits.

## Timing
- Outputs after `Reset`:
  - `rx_ready` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `start_pc` = 0, `proc_reset_l` = 0, `done` = 0, `error` = 0.
  - State = HDR_PC, accumulator = 0.
- `Reset` asserted mid-load aborts at the next edge and returns everything to the values above. Partially written memory is not cleared.
- Write timing:
  - `imem_we` is registered and is high for exactly the one cycle spent in WRITE, i.e. the cycle after the 4th payload byte is accepted.
  - `imem_addr` and `imem_wdata` are valid in that same cycle.
  - Payload throughput is therefore at most 4 bytes per 5 cycles.
- `start_pc` updates in the cycle after the 4th header byte is accepted. It is stable from then on.
- Entering RUN:
  - `proc_reset_l` and `done` rise together, in the cycle after a matching checksum byte is accepted.
  - Both stay high until `Reset`.
  - `start_pc` is already stable for at least 2 cycles before the processor leaves reset.
- `error` rises in the cycle after the offending byte is accepted. `proc_reset_l` stays 0.
- `rx_valid` may be deasserted at any point. All counters hold while no transfer occurs.

## Structure
- Shared package `loader_pkg` holds:
  - The state enum.
  - Constants `HDR_PC_BYTES = 4`, `HDR_CNT_BYTES = 2` and `WORD_BYTES = 4`.
- Sub-module `byte_assembler`: a 32-bit shift register with a byte counter.
  - Inputs: `load`, `clear` and a byte.
  - Outputs: the packed word and `word_ready` on the 4th byte.
  - Used for both header fields and the payload.
- Remaining logic is the FSM and the address/XOR datapath.

## Test plan
- Valid image with start 0x00000000, N=2, words 0x20010005 and 0x00000000, correct checksum:
  - Two `imem_we` pulses, at addresses 0x0 and 0x4 with matching data.
  - `proc_reset_l` and `done` rise 1 cycle after the checksum byte; `start_pc` = 0x0.
- Same image with the checksum byte XOR 0x01: `error` = 1, `proc_reset_l` stays 0, `done` = 0, `rx_ready` = 0.
- N = 0 with a correct checksum: no `imem_we` pulse, and `done` = 1.
- N = MAX_WORDS+1: `error` the cycle after the 2nd count byte, and no writes.
- Start address 0x00000002: `error` after the 4th header byte.
- Random `rx_valid` gaps, then `Reset` asserted after word 1 and the full image re-sent:
  - Write addresses restart at `start_pc`.
  - Final state is `done` = 1 with no spurious strobes.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and
// stream field widths.
package loader_pkg;

  typedef enum logic [2:0] {
    S_HDR_PC,
    S_HDR_CNT,
    S_PAYLOAD,
    S_WRITE,
    S_CHECK,
    S_RUN,
    S_ERROR
  } loader_state_t;

  localparam int HDR_PC_BYTES  = 4;
  localparam int HDR_CNT_BYTES = 2;
  localparam int WORD_BYTES    = 4;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == S_HDR_PC) || (s == S_HDR_CNT) || (s == S_PAYLOAD) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// MSB-first byte-to-word shift register. Used for the start address, the
// word count and every payload word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [1:0]  count,
  output logic        word_ready
);

  logic [23:0] shift;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift <= '0;
      count <= '0;
    end else if (load) begin
      shift <= {shift[15:0], data};
      count <= count + 2'd1;
    end
  end

  // The completed word is presented in the same cycle its last byte arrives.
  assign word       = {shift, data};
  assign word_ready = load && (count == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Receives a program image over a byte stream, writes it to instruction
// memory, verifies an XOR checksum and releases the processor from reset.
module program_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [31:0] start_pc,
  output logic        proc_reset_l,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MaxWordsW = 17'(MAX_WORDS);

  loader_state_t state, next_state;

  logic        xfer;
  logic        asm_load;
  logic        asm_clear;
  logic [31:0] asm_word;
  logic [1:0]  asm_count;
  logic        asm_word_ready;
  logic        hdr_cnt_last;
  logic        count_too_big;
  logic [15:0] words_left;
  logic [31:0] next_addr;
  logic [7:0]  xor_acc;

  assign rx_ready      = accepts_bytes(state);
  assign xfer          = rx_valid && rx_ready;
  assign asm_load      = xfer && (state != S_CHECK);
  assign hdr_cnt_last  = (asm_count == 2'(HDR_CNT_BYTES - 1));
  assign count_too_big = {1'b0, asm_word[15:0]} > MaxWordsW;

  byte_assembler u_asm (
    .clk        (CLK),
    .reset      (Reset),
    .load       (asm_load),
    .clear      (asm_clear),
    .data       (rx_data),
    .word       (asm_word),
    .count      (asm_count),
    .word_ready (asm_word_ready)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_HDR_PC;
    else       state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    next_state = state;
    asm_clear  = 1'b0;
    unique case (state)
      S_HDR_PC: begin
        if (asm_word_ready)
          next_state = (asm_word[1:0] != 2'b00) ? S_ERROR : S_HDR_CNT;
      end
      S_HDR_CNT: begin
        if (xfer && hdr_cnt_last) begin
          asm_clear = 1'b1;
          if (count_too_big)               next_state = S_ERROR;
          else if (asm_word[15:0] == '0)   next_state = S_CHECK;
          else                             next_state = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (asm_word_ready) next_state = S_WRITE;
      end
      S_WRITE: begin
        next_state = (words_left == '0) ? S_CHECK : S_PAYLOAD;
      end
      S_CHECK: begin
        if (xfer) next_state = (rx_data == xor_acc) ? S_RUN : S_ERROR;
      end
      S_RUN, S_ERROR: next_state = state;
      default:        next_state = S_ERROR;
    endcase
  end

  // Status outputs are registered copies of the upcoming state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      imem_we      <= 1'b0;
      done         <= 1'b0;
      proc_reset_l <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_we      <= (next_state == S_WRITE);
      done         <= (next_state == S_RUN);
      proc_reset_l <= (next_state == S_RUN);
      error        <= (next_state == S_ERROR);
    end
  end

  // Address/XOR datapath. The checksum byte itself is excluded from the XOR.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      xor_acc    <= '0;
      start_pc   <= '0;
      next_addr  <= '0;
      words_left <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      if (asm_load) xor_acc <= xor_acc ^ rx_data;

      if (state == S_HDR_PC && asm_word_ready) begin
        start_pc  <= asm_word;
        next_addr <= asm_word;
      end

      if (state == S_HDR_CNT && xfer && hdr_cnt_last)
        words_left <= asm_word[15:0];

      // Address arithmetic wraps modulo 2^32 by design.
      if (state == S_PAYLOAD && asm_word_ready) begin
        imem_addr  <= next_addr;
        imem_wdata <= asm_word;
        next_addr  <= next_addr + 32'd4;
        words_left <= words_left - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader: images are built from
// the stream format and expected writes/outcomes come from a reference model.
module tb_program_loader;

  localparam int MAX_WORDS = 64;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] start_pc;
  logic        proc_reset_l;
  logic        done;
  logic        error;

  always #5 CLK = ~CLK;

  program_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .start_pc     (start_pc),
    .proc_reset_l (proc_reset_l),
    .done         (done),
    .error        (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   we_count = 0;
  wr_t  exp_wr[$];
  logic [7:0] img[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Every write strobe must match the next expected (address, data) pair.
  always @(negedge CLK) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      we_count++;
      if (exp_wr.size() == 0) begin
        check("spurious_we", 32'd1, 32'd0);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  // Reference model: serialise an image and predict the memory writes.
  task automatic make_image(input logic [31:0] start, input logic [15:0] n,
                            input logic [7:0] flip, input bit rand_words,
                            input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
    logic [7:0]  ck;
    img.delete();
    for (int b = 3; b >= 0; b--) img.push_back(8'(start >> (8 * b)));
    img.push_back(n[15:8]);
    img.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      w = rand_words ? $urandom : ((i == 0) ? w0 : w1);
      for (int b = 3; b >= 0; b--) img.push_back(8'(w >> (8 * b)));
      if (start[1:0] == 2'b00 && int'(n) <= MAX_WORDS)
        exp_wr.push_back('{addr: start + 32'(4 * i), data: w});
    end
    ck = 8'h00;
    foreach (img[k]) ck = ck ^ img[k];
    img.push_back(ck ^ flip);
  endtask

  // Offer img[0..limit-1]; a byte moves only when valid and ready coincide.
  task automatic send_bytes(input int limit, input bit gaps);
    int idx = 0;
    int cycles = 0;
    while (idx < limit) begin
      @(negedge CLK);
      cycles++;
      if (cycles > 20 * limit + 200) begin
        check("send_timeout", 32'(idx), 32'(limit));
        break;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = img[idx];
      end
      if (rx_valid && rx_ready) begin
        idx++;
        if (idx == limit) begin
          check("pre_done", 32'(done), 32'd0);
          check("pre_error", 32'(error), 32'd0);
        end
      end
    end
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    Reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_start_pc", start_pc, 32'd0);
    check("rst_proc_reset_l", 32'(proc_reset_l), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  task automatic expect_done(input logic [31:0] start);
    check("done", 32'(done), 32'd1);
    check("proc_reset_l", 32'(proc_reset_l), 32'd1);
    check("no_error", 32'(error), 32'd0);
    check("run_rx_ready", 32'(rx_ready), 32'd0);
    check("start_pc", start_pc, start);
    check("writes_pending", 32'(exp_wr.size()), 32'd0);
    repeat (3) @(negedge CLK);
    check("done_held", 32'(done), 32'd1);
    check("start_pc_held", start_pc, start);
  endtask

  task automatic expect_error();
    int we_before = we_count;
    check("error", 32'(error), 32'd1);
    check("err_done", 32'(done), 32'd0);
    check("err_proc_reset_l", 32'(proc_reset_l), 32'd0);
    check("err_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge CLK);
    check("error_sticky", 32'(error), 32'd1);
    check("err_no_more_writes", 32'(we_count - we_before), 32'd0);
    check("err_writes_pending", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    int          we_start;
    logic [31:0] st;
    logic [15:0] n;

    Reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge CLK);
    reset_dut();

    // Directed two-word image.
    make_image(32'h0, 16'd2, 8'h00, 1'b0, 32'h20010005, 32'h0);
    send_bytes(img.size(), 1'b0);
    expect_done(32'h0);

    // Same image with a corrupted checksum.
    reset_dut();
    make_image(32'h0, 16'd2, 8'h01, 1'b0, 32'h20010005, 32'h0);
    send_bytes(img.size(), 1'b0);
    expect_error();

    // Empty image.
    reset_dut();
    we_start = we_count;
    make_image(32'h0, 16'd0, 8'h00, 1'b1, 32'h0, 32'h0);
    send_bytes(img.size(), 1'b1);
    expect_done(32'h0);
    check("n0_no_writes", 32'(we_count - we_start), 32'd0);

    // Oversized word count rejected right after the count field.
    reset_dut();
    we_start = we_count;
    make_image(32'h100, 16'(MAX_WORDS + 1), 8'h00, 1'b1, 32'h0, 32'h0);
    send_bytes(6, 1'b1);
    expect_error();
    check("big_n_no_writes", 32'(we_count - we_start), 32'd0);

    // Misaligned start address rejected after the 4th header byte.
    reset_dut();
    make_image(32'h2, 16'd1, 8'h00, 1'b1, 32'h0, 32'h0);
    send_bytes(4, 1'b0);
    expect_error();

    // Largest accepted image.
    reset_dut();
    st = $urandom & 32'hFFFF_FFFC;
    make_image(st, 16'(MAX_WORDS), 8'h00, 1'b1, 32'h0, 32'h0);
    send_bytes(img.size(), 1'b1);
    expect_done(st);

    // Random images, including one that wraps the address space.
    for (int t = 0; t < 5; t++) begin
      reset_dut();
      st = (t == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      n  = 16'($urandom_range(1, 6));
      make_image(st, n, 8'h00, 1'b1, 32'h0, 32'h0);
      send_bytes(img.size(), 1'b1);
      expect_done(st);
    end

    // Abort after word 1, then resend the full image.
    reset_dut();
    st = $urandom & 32'h0000_FFFC;
    make_image(st, 16'd3, 8'h00, 1'b1, 32'h0, 32'h0);
    send_bytes(6 + 8, 1'b1);
    @(negedge CLK);
    reset_dut();
    check("abort_pending", 32'(exp_wr.size()), 32'd1);
    exp_wr.delete();
    make_image(st, 16'd3, 8'h00, 1'b1, 32'h0, 32'h0);
    send_bytes(img.size(), 1'b1);
    expect_done(st);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
